// File: rtl/calc_sequencer_pkg.sv
// Shared types for the calc_sequencer slice: queue opcodes, error codes and FSM states.
package calc_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [1:0] {
        Q_PUSH = 2'b00,
        Q_NOP  = 2'b01,
        Q_POP  = 2'b10,
        Q_POP2 = 2'b11
    } q_op_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_TIMEOUT   = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_FETCH,
        S_WAIT_ALU,
        S_WRITE
    } state_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Command handshake between an upstream command source (master) and the sequencer (slave).
interface calc_sequencer_if #(parameter int W = 8);
    import calc_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_is_op;
    logic [W-1:0]        cmd_data;
    logic [ALU_OP_W-1:0] cmd_alu_op;

    modport master (
        output cmd_valid, cmd_is_op, cmd_data, cmd_alu_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_is_op, cmd_data, cmd_alu_op,
        output cmd_ready
    );

endinterface

// File: rtl/calc_seq_watchdog.sv
// Down-counter that flags expire once TIMEOUT cycles have elapsed after start,
// until clear disarms it.
module calc_seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] remaining;
    logic          armed;

    // start is seen one cycle before the wait begins, so load TIMEOUT-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= '0;
            armed     <= 1'b0;
        end else if (clear) begin
            armed     <= 1'b0;
        end else if (start) begin
            remaining <= CW'(TIMEOUT - 1);
            armed     <= 1'b1;
        end else if (armed && remaining != '0) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign expire = armed && (remaining == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Command sequencer in front of a queue and ALU: pushes literals, pops two operands
// per OP and writes the ALU result back. Optional ALU watchdog: CALC_SEQ_TIMEOUT_EN.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    calc_sequencer_if.slave     cmd,
    output logic                q_strobe,
    output logic [1:0]          q_opcode,
    output logic [W-1:0]        q_back,
    input  logic [2*W-1:0]      q_top_conc,
    output logic [2*W-1:0]      alu_operands,
    output logic [ALU_OP_W-1:0] alu_opcode,
    output logic                alu_start,
    input  logic [W-1:0]        alu_result,
    input  logic                alu_sync,
    output logic                res_valid,
    output logic [W-1:0]        res_data,
    output logic [3:0]          count,
    output logic [1:0]          err,
    input  logic                err_clr
);

    localparam logic [3:0] FULL = 4'(DEPTH);

    state_t state;
    logic   timed_out;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("calc_sequencer: TIMEOUT must be at least 1");
    end

`ifdef CALC_SEQ_TIMEOUT_EN
    calc_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (state == S_FETCH),
        .clear  (state == S_IDLE),
        .expire (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    // Strobes default low every cycle; a later err assignment overrides err_clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cmd.cmd_ready <= 1'b0;
            q_strobe      <= 1'b0;
            q_opcode      <= Q_NOP;
            q_back        <= '0;
            alu_operands  <= '0;
            alu_opcode    <= '0;
            alu_start     <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            count         <= '0;
            err           <= ERR_NONE;
        end else begin
            q_strobe  <= 1'b0;
            q_opcode  <= Q_NOP;
            alu_start <= 1'b0;
            res_valid <= 1'b0;
            if (err_clr) err <= ERR_NONE;

            case (state)
                S_IDLE: begin
                    cmd.cmd_ready <= 1'b1;
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        if (!cmd.cmd_is_op) begin
                            if (count == FULL) begin
                                err <= ERR_OVERFLOW;
                            end else begin
                                q_back        <= cmd.cmd_data;
                                q_opcode      <= Q_PUSH;
                                q_strobe      <= 1'b1;
                                count         <= count + 4'd1;
                                cmd.cmd_ready <= 1'b0;
                                state         <= S_PUSH;
                            end
                        end else if (count < 4'd2) begin
                            err <= ERR_UNDERFLOW;
                        end else begin
                            alu_operands  <= q_top_conc;
                            alu_opcode    <= cmd.cmd_alu_op;
                            alu_start     <= 1'b1;
                            q_opcode      <= Q_POP2;
                            q_strobe      <= 1'b1;
                            count         <= count - 4'd2;
                            cmd.cmd_ready <= 1'b0;
                            state         <= S_FETCH;
                        end
                    end
                end
                S_PUSH: begin
                    cmd.cmd_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                S_FETCH: begin
                    state <= S_WAIT_ALU;
                end
                S_WAIT_ALU: begin
                    if (alu_sync) begin
                        res_data  <= alu_result;
                        q_back    <= alu_result;
                        q_opcode  <= Q_PUSH;
                        q_strobe  <= 1'b1;
                        res_valid <= 1'b1;
                        count     <= count + 4'd1;
                        state     <= S_WRITE;
                    end else if (timed_out) begin
                        err           <= ERR_TIMEOUT;
                        cmd.cmd_ready <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    cmd.cmd_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    cmd.cmd_ready <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues expected queue/ALU/result
// transactions, a negedge monitor pops and compares them as the DUT emits them.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk;
    logic        rst;
    logic        q_strobe;
    logic [1:0]  q_opcode;
    logic [7:0]  q_back;
    logic [15:0] q_top_conc;
    logic [15:0] alu_operands;
    logic [2:0]  alu_opcode;
    logic        alu_start;
    logic [7:0]  alu_result;
    logic        alu_sync;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [3:0]  count;
    logic [1:0]  err;
    logic        err_clr;

    int passed = 0;
    int total  = 0;

    typedef struct { logic [1:0] op; logic [7:0] data; } q_txn_t;
    typedef struct { logic [15:0] operands; logic [2:0] op; } alu_txn_t;

    q_txn_t     q_exp[$];
    alu_txn_t   alu_exp[$];
    logic [7:0] res_exp[$];

    calc_sequencer_if #(.W(8)) cmd_if ();

    calc_sequencer #(.W(8), .DEPTH(8), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .q_strobe     (q_strobe),
        .q_opcode     (q_opcode),
        .q_back       (q_back),
        .q_top_conc   (q_top_conc),
        .alu_operands (alu_operands),
        .alu_opcode   (alu_opcode),
        .alu_start    (alu_start),
        .alu_result   (alu_result),
        .alu_sync     (alu_sync),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .count        (count),
        .err          (err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic noteFail(input string name);
        total++;
        $display("[TB] FAIL %s: event occurred that no stimulus expected or bound expired", name);
    endtask

    // Monitor: every DUT-emitted transaction must match the head of its queue
    initial begin
        q_txn_t   qe;
        alu_txn_t ae;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (q_strobe) begin
                    if (q_exp.size() == 0) noteFail("q_unexpected");
                    else begin
                        qe = q_exp.pop_front();
                        checkOutput("q_opcode", 32'(q_opcode), 32'(qe.op));
                        if (qe.op == Q_PUSH) checkOutput("q_back", 32'(q_back), 32'(qe.data));
                    end
                end
                if (alu_start) begin
                    if (alu_exp.size() == 0) noteFail("alu_unexpected");
                    else begin
                        ae = alu_exp.pop_front();
                        checkOutput("alu_operands", 32'(alu_operands), 32'(ae.operands));
                        checkOutput("alu_opcode", 32'(alu_opcode), 32'(ae.op));
                    end
                end
                if (res_valid) begin
                    if (res_exp.size() == 0) noteFail("res_unexpected");
                    else checkOutput("res_data", 32'(res_data), 32'(res_exp.pop_front()));
                end
            end
        end
    end

    task automatic checkResetState();
        checkOutput("rst_cmd_ready", 32'(cmd_if.cmd_ready), 0);
        checkOutput("rst_q_strobe", 32'(q_strobe), 0);
        checkOutput("rst_q_opcode", 32'(q_opcode), 32'(Q_NOP));
        checkOutput("rst_q_back", 32'(q_back), 0);
        checkOutput("rst_alu_operands", 32'(alu_operands), 0);
        checkOutput("rst_alu_opcode", 32'(alu_opcode), 0);
        checkOutput("rst_alu_start", 32'(alu_start), 0);
        checkOutput("rst_res_valid", 32'(res_valid), 0);
        checkOutput("rst_res_data", 32'(res_data), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_err", 32'(err), 0);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!cmd_if.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.cmd_ready) noteFail("idle_timeout");
    endtask

    // Entered and left on a negedge; accept=0 means the command must be dropped
    task automatic applyStimulus(input logic is_op, input logic [7:0] data, input logic [2:0] op,
                                 input logic clr, input logic accept);
        int n = 0;
        cmd_if.cmd_is_op  = is_op;
        cmd_if.cmd_data   = data;
        cmd_if.cmd_alu_op = op;
        err_clr           = clr;
        cmd_if.cmd_valid  = 1'b1;
        while (!cmd_if.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.cmd_ready) begin
            noteFail("cmd_ready_timeout");
            cmd_if.cmd_valid = 1'b0;
            err_clr          = 1'b0;
            return;
        end
        if (accept) begin
            if (is_op) begin
                alu_exp.push_back('{q_top_conc, op});
                q_exp.push_back('{Q_POP2, 8'h00});
            end else begin
                q_exp.push_back('{Q_PUSH, data});
            end
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        err_clr          = 1'b0;
        checkOutput("accept_strobe", 32'(q_strobe), 32'(accept));
    endtask

    task automatic aluRespond(input logic [7:0] result, input int delay);
        q_exp.push_back('{Q_PUSH, result});
        res_exp.push_back(result);
        repeat (delay) @(negedge clk);
        alu_result = result;
        alu_sync   = 1'b1;
        @(negedge clk);
        alu_sync   = 1'b0;
    endtask

    initial begin
        rst               = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_is_op  = 1'b0;
        cmd_if.cmd_data   = '0;
        cmd_if.cmd_alu_op = '0;
        q_top_conc        = '0;
        alu_result        = '0;
        alu_sync          = 1'b0;
        err_clr           = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b1;
        waitIdle();

        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 8'(i), 3'd0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("count_after_4_push", 32'(count), 4);

        q_top_conc = 16'h0304;
        applyStimulus(1'b1, 8'h00, 3'd2, 1'b0, 1'b1);
        checkOutput("count_after_pop2", 32'(count), 2);
        aluRespond(8'd7, 2);
        waitIdle();
        checkOutput("count_after_write", 32'(count), 3);
        checkOutput("res_data_held", 32'(res_data), 7);

        for (int i = 5; i <= 9; i++) applyStimulus(1'b0, 8'(i), 3'd0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("count_full", 32'(count), 8);
        applyStimulus(1'b0, 8'hAA, 3'd0, 1'b0, 1'b0);
        checkOutput("err_overflow", 32'(err), 32'(ERR_OVERFLOW));
        checkOutput("count_after_overflow", 32'(count), 8);

        q_top_conc = 16'h0809;
        applyStimulus(1'b1, 8'h00, 3'd5, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);
        rst = 1'b1;
        waitIdle();

        applyStimulus(1'b0, 8'h11, 3'd0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("count_one", 32'(count), 1);
        q_top_conc = 16'h0011;
        applyStimulus(1'b1, 8'h00, 3'd1, 1'b0, 1'b0);
        checkOutput("err_underflow", 32'(err), 32'(ERR_UNDERFLOW));
        checkOutput("count_after_underflow", 32'(count), 1);
        applyStimulus(1'b1, 8'h00, 3'd1, 1'b1, 1'b0);
        checkOutput("err_new_beats_clr", 32'(err), 32'(ERR_UNDERFLOW));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("err_cleared", 32'(err), 32'(ERR_NONE));

        applyStimulus(1'b0, 8'h21, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h22, 3'd0, 1'b0, 1'b1);
        waitIdle();
        q_top_conc = 16'h2122;
        applyStimulus(1'b1, 8'h00, 3'd3, 1'b0, 1'b1);
`ifdef CALC_SEQ_TIMEOUT_EN
        waitIdle();
        checkOutput("err_timeout", 32'(err), 32'(ERR_TIMEOUT));
        checkOutput("count_after_timeout", 32'(count), 1);
        checkOutput("res_data_no_write", 32'(res_data), 0);
`else
        repeat (20) @(negedge clk);
        checkOutput("still_waiting_ready", 32'(cmd_if.cmd_ready), 0);
        checkOutput("no_timeout_err", 32'(err), 32'(ERR_NONE));
        aluRespond(8'h43, 0);
        waitIdle();
        checkOutput("count_after_late_sync", 32'(count), 2);
        checkOutput("res_data_late", 32'(res_data), 32'h43);
`endif

        repeat (3) @(negedge clk);
        checkOutput("q_exp_drained", 32'(q_exp.size()), 0);
        checkOutput("alu_exp_drained", 32'(alu_exp.size()), 0);
        checkOutput("res_exp_drained", 32'(res_exp.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
